// File: rtl/tmf_pkg.sv
// tmf_pkg: shared FSM state type and sizing helpers for the time-multiplexed FIR controller.
package tmf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmf_state_e;

  // The accumulator needs headroom for N full-width products.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  function automatic logic [63:0] round_const(input int wfo);
    return 64'd1 << (wfo - 1);
  endfunction

endpackage

// File: rtl/tmf_tap_sequencer_if.sv
// tmf_tap_sequencer_if: sample handshake, coefficient MUX select and output handshake of the FIR controller.
interface tmf_tap_sequencer_if #(
  parameter int N   = 3,
  parameter int WIO = 2,
  parameter int WFO = 6
);
  localparam int W = WIO + WFO;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic [N-1:0]        one_hot;
  logic signed [W-1:0] coeff_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic                busy;

  modport master (
    output in_valid, in_data, coeff_in, out_ready,
    input  in_ready, one_hot, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coeff_in, out_ready,
    output in_ready, one_hot, out_valid, out_data, busy
  );

endinterface

// File: rtl/tmf_mac.sv
// tmf_mac: signed multiply-accumulate with round-half-up output stage.
// Output overflow wraps by default; define TMF_SAT_EN to saturate and raise a sticky flag.
module tmf_mac
  import tmf_pkg::*;
#(
  parameter int N   = 3,
  parameter int WIO = 2,
  parameter int WFO = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic                      i_last,
  input  logic signed [WIO+WFO-1:0] i_sample,
  input  logic signed [WIO+WFO-1:0] i_coeff,
  output logic signed [WIO+WFO-1:0] o_result
`ifdef TMF_SAT_EN
  ,
  output logic                      o_satFlag
`endif
);
  localparam int W     = WIO + WFO;
  localparam int ACC_W = acc_width(N, W);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(WFO));

  logic signed [2*W-1:0]   w_product;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_biased;
  logic signed [W-1:0]     w_result;
  logic signed [W-1:0]     r_result;

  assign w_product = (2*W)'(i_sample) * (2*W)'(i_coeff);
  assign w_sum     = r_acc + ACC_W'(w_product);
  assign w_biased  = w_sum + RND;

`ifdef TMF_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_ovf;
  logic                    r_satFlag;

  assign w_shifted = w_biased >>> WFO;
  assign w_ovf     = (w_shifted > SAT_MAX) || (w_shifted < SAT_MIN);
  assign w_result  = !w_ovf ? w_shifted[W-1:0] :
                     (w_shifted[ACC_W-1] ? SAT_MIN[W-1:0] : SAT_MAX[W-1:0]);
  assign o_satFlag = r_satFlag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_satFlag <= 1'b0;
    end else if (i_en && i_last && w_ovf) begin
      r_satFlag <= 1'b1;
    end
  end
`else
  assign w_result = W'(w_biased >>> WFO);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_result <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
      if (i_last) begin
        r_result <= w_result;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/tmf_tap_sequencer.sv
// tmf_tap_sequencer: FSM, delay line and handshakes of a time-multiplexed FIR, one tap per clock.
// Define TMF_SAT_EN for a saturating output and the sticky sat_flag port.
module tmf_tap_sequencer
  import tmf_pkg::*;
#(
  parameter int N   = 3,
  parameter int WIO = 2,
  parameter int WFO = 6
) (
  input  logic               clk,
  input  logic               reset,
  tmf_tap_sequencer_if.slave bus
`ifdef TMF_SAT_EN
  ,
  output logic               sat_flag
`endif
);
  localparam int W     = WIO + WFO;
  localparam int TAP_W = $clog2(N);

  tmf_state_e          r_state;
  tmf_state_e          w_nextState;
  logic [TAP_W-1:0]    r_tap;
  logic signed [W-1:0] r_delay [N];
  logic                w_accept;
  logic                w_lastTap;
  logic                w_clr;
  logic                w_en;
  logic signed [W-1:0] w_macResult;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_lastTap = (r_tap == TAP_W'(N - 1));

  always_comb begin
    w_nextState   = r_state;
    w_clr         = 1'b0;
    w_en          = 1'b0;
    bus.one_hot   = '0;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_clr       = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        bus.one_hot = {{(N-1){1'b0}}, 1'b1} << r_tap;
        bus.busy    = 1'b1;
        w_en        = 1'b1;
        if (w_lastTap) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Reset also flushes the delay line so an aborted sample leaves no history behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tap   <= '0;
      for (int i = 0; i < N; i++) begin
        r_delay[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_delay[0] <= bus.in_data;
        for (int i = 1; i < N; i++) begin
          r_delay[i] <= r_delay[i-1];
        end
        r_tap <= '0;
      end else if (w_en) begin
        r_tap <= w_lastTap ? '0 : r_tap + 1'b1;
      end
    end
  end

  tmf_mac #(
    .N   (N),
    .WIO (WIO),
    .WFO (WFO)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_last    (w_lastTap),
    .i_sample  (r_delay[r_tap]),
    .i_coeff   (bus.coeff_in),
    .o_result  (w_macResult)
`ifdef TMF_SAT_EN
    ,
    .o_satFlag (sat_flag)
`endif
  );

  assign bus.out_data = w_macResult;

endmodule

// File: tb/tb_tmf_tap_sequencer.sv
// tb_tmf_tap_sequencer: directed self-checking bench for tmf_tap_sequencer (N=3, Q2.6).
// Expected values follow TMF_SAT_EN when it is defined.
module tb_tmf_tap_sequencer;

  logic clk;
  logic reset;
  logic satFlag;
  logic [7:0] coeffTable [3];
  int assertCount;
  int failCount;

  tmf_tap_sequencer_if #(.N(3), .WIO(2), .WFO(6)) bus ();

  tmf_tap_sequencer #(.N(3), .WIO(2), .WFO(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef TMF_SAT_EN
    ,
    .sat_flag (satFlag)
`endif
  );

`ifndef TMF_SAT_EN
  assign satFlag = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient MUX model: returns the table entry selected by one_hot.
  always_comb begin
    bus.coeff_in = '0;
    for (int i = 0; i < 3; i++) begin
      if (bus.one_hot[i]) bus.coeff_in = coeffTable[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic setTable(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    coeffTable[0] = c0;
    coeffTable[1] = c1;
    coeffTable[2] = c2;
  endtask

  task automatic waitOutput(input string tag, input logic [7:0] expected);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      stepClock();
      lat++;
    end
    checkOutput({tag, "_lat"}, 8'(lat), 8'd3);
    checkOutput({tag, "_data"}, bus.out_data, expected);
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] sample, input logic [7:0] expected);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = sample;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      stepClock();
      n++;
    end
    checkOutput({tag, "_rdy"}, 8'(bus.in_ready), 8'd1);
    stepClock();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    waitOutput(tag, expected);
  endtask

  task automatic runSample(input string tag, input logic [7:0] sample, input logic [7:0] expected);
    applyStimulus(tag, sample, expected);
    stepClock();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] walkExp [4];
    walkExp[0] = 3'b001;
    walkExp[1] = 3'b010;
    walkExp[2] = 3'b100;
    walkExp[3] = 3'b000;
    assertCount   = 0;
    failCount     = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    setTable(8'h20, 8'h10, 8'h08);
    stepClock();
    stepClock();
    reset = 1'b0;

    checkOutput("rst_in_ready", 8'(bus.in_ready), 8'd1);
    checkOutput("rst_out_valid", 8'(bus.out_valid), 8'd0);
    checkOutput("rst_one_hot", 8'(bus.one_hot), 8'd0);
    checkOutput("rst_out_data", bus.out_data, 8'h00);
    checkOutput("rst_busy", 8'(bus.busy), 8'd0);
`ifdef TMF_SAT_EN
    checkOutput("rst_sat_flag", 8'(satFlag), 8'd0);
`endif

    $display("[TB] impulse response");
    runSample("imp0", 8'h40, 8'h20);
    runSample("imp1", 8'h00, 8'h10);
    runSample("imp2", 8'h00, 8'h08);
    runSample("imp3", 8'h00, 8'h00);

    $display("[TB] tap walk");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    stepClock();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("walk_one_hot%0d", i), 8'(bus.one_hot), 8'(walkExp[i]));
      checkOutput($sformatf("walk_in_ready%0d", i), 8'(bus.in_ready), 8'd0);
      stepClock();
    end
    checkOutput("walk_ready_back", 8'(bus.in_ready), 8'd1);

    $display("[TB] negative rounding");
    setTable(8'h20, 8'h00, 8'h00);
    runSample("neg", 8'hC1, 8'hE1);

    $display("[TB] overflow");
    setTable(8'h7F, 8'h7F, 8'h7F);
    runSample("ovf0", 8'h7F, 8'h7F);
`ifdef TMF_SAT_EN
    runSample("ovf1", 8'h7F, 8'h7F);
    runSample("ovf2", 8'h7F, 8'h7F);
    checkOutput("ovf_sat_flag", 8'(satFlag), 8'd1);
`else
    runSample("ovf1", 8'h7F, 8'h7B);
    runSample("ovf2", 8'h7F, 8'hF4);
`endif

    $display("[TB] backpressure");
    setTable(8'h20, 8'h10, 8'h08);
    bus.out_ready = 1'b0;
    applyStimulus("bp", 8'h40, 8'h50);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), 8'(bus.out_valid), 8'd1);
      checkOutput($sformatf("bp_data%0d", i), bus.out_data, 8'h50);
      checkOutput($sformatf("bp_in_ready%0d", i), 8'(bus.in_ready), 8'd0);
      stepClock();
    end
    bus.out_ready = 1'b1;
    stepClock();
    checkOutput("bp_idle_ready", 8'(bus.in_ready), 8'd1);
    checkOutput("bp_idle_valid", 8'(bus.out_valid), 8'd0);
    stepClock();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    checkOutput("bp_accept_busy", 8'(bus.busy), 8'd1);
    checkOutput("bp_accept_one_hot", 8'(bus.one_hot), 8'd1);
    waitOutput("bp_next", 8'h28);
    stepClock();

    $display("[TB] reset during RUN");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h40;
    stepClock();
    bus.in_valid = 1'b0;
    stepClock();
    checkOutput("mid_one_hot_tap1", 8'(bus.one_hot), 8'd2);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("mid_one_hot", 8'(bus.one_hot), 8'd0);
    checkOutput("mid_out_valid", 8'(bus.out_valid), 8'd0);
    checkOutput("mid_in_ready", 8'(bus.in_ready), 8'd1);
    checkOutput("mid_busy", 8'(bus.busy), 8'd0);
`ifdef TMF_SAT_EN
    checkOutput("mid_sat_flag", 8'(satFlag), 8'd0);
`endif
    runSample("post_rst", 8'h40, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
